// File: rtl/router_out_arbiter.sv
// -----------------------------------------------------------------------------
// router_out_arbiter
//
// Output-port arbiter and forwarding stage for the 16-port serial router.
// Header decoders on the input ports raise req[i] when they hold a packet for
// this output. One requester is granted in round-robin order. The grant stays
// locked until the packet's last bit. The winner's din/valid_n/frame_n are
// forwarded onto dout/valido_n/frameo_n through one register stage.
//
// Optional feature: define ARB_TIMEOUT_EN to enable the transfer watchdog.
// With it, a transfer that runs MAX_XFER cycles without a last bit is
// force-closed and timeout pulses for one cycle. Without it, timeout is tied
// low and transfers are unbounded.
//
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   req        in   [NUM_IN] per-input request for this output
//   din        in   [NUM_IN] per-input serial data
//   valid_n    in   [NUM_IN] per-input data valid, active-low
//   frame_n    in   [NUM_IN] per-input frame, active-low, high on last bit
//   gnt        out  [NUM_IN] one-hot grant, zero when idle
//   dout       out  forwarded serial data
//   valido_n   out  forwarded valid, active-low
//   frameo_n   out  forwarded frame, active-low
//   busy_n     out  low while the output is owned
//   timeout    out  one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module router_out_arbiter #(
  parameter int NUM_IN   = 16,
  parameter int MAX_XFER = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] din,
  input  logic [NUM_IN-1:0] valid_n,
  input  logic [NUM_IN-1:0] frame_n,
  output logic [NUM_IN-1:0] gnt,
  output logic              dout,
  output logic              valido_n,
  output logic              frameo_n,
  output logic              busy_n,
  output logic              timeout
);

  // The rotating pointer is 4 bits wide, and the watchdog counter is 16 bits.
  if (NUM_IN < 2 || NUM_IN > 16 || MAX_XFER < 1 || MAX_XFER > 65535) begin : g_bad_params
    $error("router_out_arbiter: NUM_IN must be 2..16 and MAX_XFER 1..65535");
  end

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t      state;
  // last is the most recently granted input. During XFER it is also the owner,
  // so it selects the forwarded input without a separate index register.
  logic [3:0]  last;
  logic [3:0]  win_idx;
  logic [3:0]  cand;
  logic        win_found;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] xfer_cnt;
  logic        timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Round-robin pick: scan last+1, last+2, ... modulo NUM_IN and take the
  // first requester. The scan ends at last itself, so a lone requester is
  // re-granted right after its own release.
  // NOTE: every signal written here gets a default before the loop, so no
  // path leaves a value held and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    cand      = '0;
    for (int i = 1; i <= NUM_IN; i++) begin
      cand = 4'((int'(last) + i) % NUM_IN);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments. Every register then
  // sees the pre-edge values of the others, which gives the one-cycle
  // forwarding pipeline without races between always blocks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // An in-flight packet is dropped. No closing frame bit is emitted.
      state    <= IDLE;
      last     <= 4'(NUM_IN - 1);
      gnt      <= '0;
      dout     <= 1'b0;
      valido_n <= 1'b1;
      frameo_n <= 1'b1;
      busy_n   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      xfer_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // This is also the gap cycle after a release. The last bit leaves
          // the output register here, and the next owner can be granted on
          // the same edge.
          dout     <= 1'b0;
          valido_n <= 1'b1;
          frameo_n <= 1'b1;
          if (win_found) begin
            state  <= XFER;
            gnt    <= {{(NUM_IN-1){1'b0}}, 1'b1} << win_idx;
            last   <= win_idx;
            busy_n <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            xfer_cnt <= '0;
`endif
          end
        end

        XFER: begin
          // req is ignored here. The grant holds until the owner's last bit.
          dout     <= din[last];
          valido_n <= valid_n[last];
          frameo_n <= frame_n[last];
`ifdef ARB_TIMEOUT_EN
          xfer_cnt <= xfer_cnt + 16'd1;
`endif
          if (frame_n[last]) begin
            // The last bit is registered on the same edge that drops the grant.
            state  <= IDLE;
            gnt    <= '0;
            busy_n <= 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          else if (xfer_cnt == 16'(MAX_XFER - 1)) begin
            // Forced close. The output shows an idle frame in place of the
            // data bit. A genuine last bit on this edge would have won above.
            state     <= IDLE;
            gnt       <= '0;
            busy_n    <= 1'b1;
            dout      <= 1'b0;
            valido_n  <= 1'b1;
            frameo_n  <= 1'b1;
            timeout_q <= 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Per-output-port arbiter and forwarding stage for the 16-port serial router. Input-port header decoders raise a request once a packet's address and padding have been decoded for this output. The block grants one requester round-robin, locks the grant for the whole packet, and forwards the winner's `din`/`valid_n`/`frame_n` onto this port's `dout`/`valido_n`/`frameo_n` with one cycle of latency. The router instantiates one copy per output port.

## Interface

Parameters:
- `NUM_IN`, 16, number of requesting input ports.
- `MAX_XFER`, 1024, timeout limit in transfer cycles. Used only with `ARB_TIMEOUT_EN`; must be < 2^16.

Ports:
- `clock` input 1: the single clock; all state changes on its rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `req` input NUM_IN: `req[i]` high means input i holds a packet for this output.
- `din` input NUM_IN: serial data bit from each input port.
- `valid_n` input NUM_IN: active-low per-input data-valid.
- `frame_n` input NUM_IN: active-low per-input frame; goes high on the last payload bit.
- `gnt` output NUM_IN: one-hot grant, all zero when idle.
- `dout` output 1: forwarded serial data.
- `valido_n` output 1: forwarded valid, active-low.
- `frameo_n` output 1: forwarded frame, active-low.
- `busy_n` output 1: low while the output is owned.
- `timeout` output 1: one-cycle pulse when a transfer is forcibly released.

## Operation

- States: IDLE and XFER. The round-robin pointer `last` is 4 bits wide.
- **Reset (asynchronous, immediate):**
  - State goes to IDLE and `last` to NUM_IN-1, so input 0 has top priority.
  - `gnt`=0, `dout`=0, `valido_n`=1, `frameo_n`=1, `busy_n`=1, `timeout`=0.
  - An in-flight packet is dropped with no partial frame-close.
- **IDLE:**
  - Outputs are held at their reset values.
  - If `req`≠0 at an edge, the winner is the first set bit scanning `last`+1, `last`+2, … modulo NUM_IN.
  - At that edge: `gnt` becomes one-hot(winner), `last` becomes winner, `busy_n` goes 0, and state moves to XFER.
- **XFER, granted input g:**
  - Each edge registers `dout`←`din[g]`, `valido_n`←`valid_n[g]`, `frameo_n`←`frame_n[g]`.
  - If `frame_n[g]`=1 at an edge (last bit), the same edge registers that bit and sets state to IDLE, `gnt`=0, `busy_n`=1.
  - The following IDLE edge returns `dout`/`valido_n`/`frameo_n` to their idle values.
  - `req` is ignored in XFER. The grant is locked regardless of `req[g]` dropping.
  - Other inputs' `din`/`valid_n`/`frame_n` have no effect.
- **Boundary conditions:**
  - Simultaneous requests resolve strictly by the rotating order; there is no fixed priority after the first grant.
  - A requester re-requesting immediately after release waits behind all other pending requesters.
  - A single requester is re-granted in the IDLE cycle following its release.
  - An `frame_n[g]` high on the first XFER edge is a 1-bit packet: one bit is forwarded, then release.

## Timing

- Grant latency: `req` sampled at edge N gives `gnt`/`busy_n` valid after edge N.
- The granted input drives payload starting in the cycle it sees `gnt`.
- Forwarding latency: exactly 1 clock from `din[g]`/`valid_n[g]`/`frame_n[g]` to `dout`/`valido_n`/`frameo_n`.
- Minimum gap between consecutive grants: 1 IDLE cycle, in which the last bit is on the output.
- `gnt` drops on the same edge that registers the last bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

- **Macro `ARB_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on grant and increments on each XFER edge.
  - If the counter equals MAX_XFER-1 and `frame_n[g]`=0 at an edge, the block forces release at that edge:
    - state goes to IDLE, `gnt`=0, `busy_n`=1;
    - `frameo_n`=1, `valido_n`=1, `dout`=0;
    - `timeout`=1 for exactly one cycle.
  - A normal last bit on the same edge takes precedence, with no timeout.
- **Macro not defined:** no counter exists, `timeout` is tied to 0, and transfers are unbounded.

## Test plan

- **Reset defaults:** assert `reset_n`=0 mid-XFER with no clock edge. Outputs immediately show `gnt`=0, `busy_n`=1, `frameo_n`=1, `valido_n`=1, `dout`=0.
- **Single packet:** `req`=0x0004, then an 8-bit payload 0xA5 LSB first on input 2. Expected `gnt`=0x0004 one cycle later, bits 1,0,1,0,0,1,0,1 on `dout` each delayed 1 cycle, `frameo_n` high with the 8th bit, `gnt`=0 on the same edge.
- **Round-robin fairness:** `req`=0xFFFF held, each packet 4 bits. Grant order is 0,1,2,…,15,0, with exactly one IDLE cycle between grants.
- **Lock and isolation:** input 3 granted. Toggle `req`, `din`, `valid_n`, `frame_n` on inputs 0, 5, 15 and drop `req[3]`. Output matches input 3's stream only, and `gnt` is stable until input 3's last bit.
- **Wrap priority:** after a grant to input 15, `req`=0x8001. Input 0 is granted next; input 15 is granted after input 0's packet.
- **Timeout (`ARB_TIMEOUT_EN`, MAX_XFER=8):** input 1 granted and holds `frame_n`=0. On the 8th XFER edge `frameo_n`=1, `gnt`=0, and `timeout` pulses for one cycle. Without the macro, the grant persists indefinitely and `timeout` stays 0.
